// File: rtl/puart_if.sv
// rtl/puart_if.sv - host-side bus of the puart: transmit strobe/data, receive FIFO and error flags
//
// Signals:
//   wr, tx_data           host -> uart : start a transmission
//   busy                  uart -> host : transmitter not idle
//   rd                    host -> uart : pop receive FIFO head
//   rx_data, valid        uart -> host : FIFO head (first-word-fall-through), FIFO not empty
//   rx_count              uart -> host : FIFO occupancy
//   clr_err               host -> uart : clear sticky flags
//   frame_err, parity_err, overrun      : sticky error flags
// Modports: master = host side, slave = uart side.
interface puart_if #(
    parameter int DATA_BITS = 8,
    parameter int RX_DEPTH  = 16
);
    logic                       wr;
    logic [DATA_BITS-1:0]       tx_data;
    logic                       busy;
    logic                       rd;
    logic [DATA_BITS-1:0]       rx_data;
    logic                       valid;
    logic [$clog2(RX_DEPTH):0]  rx_count;
    logic                       clr_err;
    logic                       frame_err;
    logic                       parity_err;
    logic                       overrun;

    modport master (
        output wr, tx_data, rd, clr_err,
        input  busy, rx_data, valid, rx_count, frame_err, parity_err, overrun
    );

    modport slave (
        input  wr, tx_data, rd, clr_err,
        output busy, rx_data, valid, rx_count, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/puart.sv
// rtl/puart.sv - UART with x16 oversampled receiver, receive FIFO and sticky error flags
//
// Ports:
//   clk     : single clock, rising edge
//   resetq  : asynchronous active-low reset
//   rx      : serial input, asynchronous to clk
//   tx      : serial output, idle high
//   bus     : puart_if.slave (transmit strobe/data, receive FIFO, error flags)
module puart #(
    parameter int CLKFREQ   = 30000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 16
) (
    input  logic    clk,
    input  logic    resetq,
    input  logic    rx,
    output logic    tx,
    puart_if.slave  bus
);
    localparam int DIV_RAW = CLKFREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(RX_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

    tx_state_t              tx_state_q, tx_state_d;
    logic [DW-1:0]          tx_div_q, tx_div_d;
    logic [3:0]             tx_tick_q, tx_tick_d;
    logic [3:0]             tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_q, tx_d;
    logic                   tx_tick_ev, tx_bit_end;

    assign tx_tick_ev = (tx_div_q == DIV_LAST);
    assign tx_bit_end = tx_tick_ev && (tx_tick_q == 4'd15);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;

        if (tx_state_q != TX_IDLE) begin
            tx_div_d = tx_tick_ev ? '0 : tx_div_q + 1'b1;
            if (tx_tick_ev) begin
                tx_tick_d = tx_tick_q + 1'b1;
            end
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (bus.wr) begin
                    tx_state_d = TX_START;
                    tx_shift_d = bus.tx_data;
                    tx_par_d   = (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
                    tx_d       = 1'b0;
                    tx_div_d   = '0;
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                        tx_bit_d = '0;
                        if (PARITY != 0) begin
                            tx_state_d = TX_PAR;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        tx_d     = tx_shift_d[0];
                    end
                end
            end
            TX_PAR: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 4'(STOP_BITS - 1)) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= TX_IDLE;
            tx_div_q   <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign bus.busy = (tx_state_q != TX_IDLE);

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    logic                   rx_meta_q, rx_sync_q;
    rx_state_t              rx_state_q, rx_state_d;
    logic [DW-1:0]          rx_div_q, rx_div_d;
    logic [3:0]             rx_tick_q, rx_tick_d;
    logic [3:0]             rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_ok_q, rx_par_ok_d;
    // Blocks a new start after a frame until the line has been seen high,
    // so a held-low line (break / bad stop) does not retrigger.
    logic                   rx_armed_q, rx_armed_d;
    logic                   rx_tick_ev, rx_sample;
    logic                   rx_par_exp;
    logic                   rx_push, frame_ev, par_ev;

    assign rx_tick_ev = (rx_div_q == DIV_LAST);
    assign rx_sample  = rx_tick_ev && (rx_tick_q == 4'd15);
    assign rx_par_exp = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_div_d    = rx_div_q;
        rx_tick_d   = rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_ok_d = rx_par_ok_q;
        rx_armed_d  = rx_armed_q;
        rx_push     = 1'b0;
        frame_ev    = 1'b0;
        par_ev      = 1'b0;

        if (rx_state_q != RX_IDLE) begin
            rx_div_d = rx_tick_ev ? '0 : rx_div_q + 1'b1;
            if (rx_tick_ev) begin
                rx_tick_d = rx_tick_q + 1'b1;
            end
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_sync_q) begin
                    rx_armed_d = 1'b1;
                end else if (rx_armed_q) begin
                    rx_state_d = RX_START;
                    rx_div_d   = '0;
                    rx_tick_d  = '0;
                end
            end
            RX_START: begin
                // Mid-start sample; realigning tick to 0 here puts every
                // later sample 16 ticks on, at the centre of each bit.
                if (rx_tick_ev && rx_tick_q == 4'd7) begin
                    rx_tick_d = '0;
                    if (!rx_sync_q) begin
                        rx_state_d  = RX_DATA;
                        rx_bit_d    = '0;
                        rx_par_ok_d = 1'b1;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == 4'(DATA_BITS - 1)) begin
                        rx_bit_d   = '0;
                        rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_PAR: begin
                if (rx_sample) begin
                    rx_state_d = RX_STOP;
                    if (rx_sync_q != rx_par_exp) begin
                        par_ev      = 1'b1;
                        rx_par_ok_d = 1'b0;
                    end
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_d = RX_IDLE;
                    rx_armed_d = 1'b0;
                    if (rx_sync_q) begin
                        rx_push = rx_par_ok_q;
                    end else begin
                        frame_ev = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_div_q    <= '0;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_ok_q <= 1'b1;
            rx_armed_q  <= 1'b1;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_div_q    <= rx_div_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_ok_q <= rx_par_ok_d;
            rx_armed_q  <= rx_armed_d;
        end
    end

    // ---------------- receive FIFO and flags ----------------
    logic [DATA_BITS-1:0]   fifo_mem [RX_DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count;
    logic                   full, empty, do_push, do_pop, ovr_ev;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == (AW+1)'(RX_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = bus.rd && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = rx_push && (!full || bus.rd);
    assign ovr_ev  = rx_push && full && !bus.rd;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        // A new event wins over a simultaneous clear.
        frame_err_d  = frame_ev || (frame_err_q  && !bus.clr_err);
        parity_err_d = par_ev   || (parity_err_q && !bus.clr_err);
        overrun_d    = ovr_ev   || (overrun_q    && !bus.clr_err);
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= rx_shift_q;
        end
    end

    assign bus.rx_data    = fifo_mem[rd_ptr_q[AW-1:0]];
    assign bus.valid      = !empty;
    assign bus.rx_count   = count;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_puart.sv
// tb/tb_puart.sv - self-checking bench for puart: 8N1 loopback instance and 8E1 bench-driven receiver
module tb_puart;
    localparam int BAUD    = 115200;
    localparam int CLKFREQ = BAUD * 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetq_a, resetq_b;
    logic tx_a, tx_b, rx_b;

    puart_if #(.DATA_BITS(8), .RX_DEPTH(4))  ifa ();
    puart_if #(.DATA_BITS(8), .RX_DEPTH(16)) ifb ();

    puart #(
        .CLKFREQ(CLKFREQ), .BAUD(BAUD), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .RX_DEPTH(4)
    ) dut_a (
        .clk(clk), .resetq(resetq_a), .rx(tx_a), .tx(tx_a), .bus(ifa)
    );

    puart #(
        .CLKFREQ(CLKFREQ), .BAUD(BAUD), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .RX_DEPTH(16)
    ) dut_b (
        .clk(clk), .resetq(resetq_b), .rx(rx_b), .tx(tx_b), .bus(ifb)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic       exp_tx[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Sends one byte on dut_a and checks the serial waveform and busy length.
    task automatic tx_frame_a(input logic [7:0] d);
        int t;
        int cnt;
        t = 0;
        while (ifa.busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("tx_idle_before_wr", ifa.busy, 0);
        exp_tx.delete();
        exp_tx.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_tx.push_back(d[i]);
        exp_tx.push_back(1'b1);
        ifa.tx_data = d;
        ifa.wr      = 1'b1;
        @(negedge clk);
        ifa.wr = 1'b0;
        cnt = 0;
        while (ifa.busy && cnt < 2000) begin
            if (cnt % 64 == 32 && exp_tx.size() > 0) begin
                check($sformatf("tx_bit%0d_of_%02h", cnt / 64, d), tx_a, exp_tx.pop_front());
            end
            cnt++;
            @(negedge clk);
        end
        check("busy_len", cnt, 640);
        check("tx_idle_after", tx_a, 1);
    endtask

    task automatic rx_pop_a();
        int t;
        t = 0;
        while (!ifa.valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("a_valid", ifa.valid, 1);
        if (exp_a.size() > 0) check("a_rx_data", ifa.rx_data, exp_a.pop_front());
        ifa.rd = 1'b1;
        @(negedge clk);
        ifa.rd = 1'b0;
    endtask

    task automatic rx_pop_b();
        int t;
        t = 0;
        while (!ifb.valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("b_valid", ifb.valid, 1);
        if (exp_b.size() > 0) check("b_rx_data", ifb.rx_data, exp_b.pop_front());
        ifb.rd = 1'b1;
        @(negedge clk);
        ifb.rd = 1'b0;
    endtask

    // Drives one 8-bit + parity + stop frame into dut_b, 64 clocks per bit.
    task automatic drive_b(input logic [7:0] d, input logic p, input logic s);
        rx_b = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_b = d[i];
            repeat (64) @(negedge clk);
        end
        rx_b = p;
        repeat (64) @(negedge clk);
        rx_b = s;
        repeat (64) @(negedge clk);
        rx_b = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic pulse_clr_b();
        ifb.clr_err = 1'b1;
        @(negedge clk);
        ifb.clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetq_a = 1'b0;
        resetq_b = 1'b0;
        rx_b = 1'b1;
        ifa.wr = 1'b0; ifa.tx_data = '0; ifa.rd = 1'b0; ifa.clr_err = 1'b0;
        ifb.wr = 1'b0; ifb.tx_data = '0; ifb.rd = 1'b0; ifb.clr_err = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx",        tx_a, 1);
        check("rst_busy",      ifa.busy, 0);
        check("rst_valid",     ifa.valid, 0);
        check("rst_count",     ifa.rx_count, 0);
        check("rst_flags",     {ifa.frame_err, ifa.parity_err, ifa.overrun}, 0);
        resetq_a = 1'b1;
        resetq_b = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 waveform of 0xA5, looped back into the receiver
        exp_a.push_back(8'hA5);
        tx_frame_a(8'hA5);
        rx_pop_a();

        // loopback 0x3C: occupancy 1, then empty after one read
        exp_a.push_back(8'h3C);
        tx_frame_a(8'h3C);
        check("lb_valid", ifa.valid, 1);
        check("lb_count1", ifa.rx_count, 1);
        rx_pop_a();
        check("lb_valid0", ifa.valid, 0);
        check("lb_count0", ifa.rx_count, 0);

        // five frames into a 4-deep FIFO with no reads
        for (int i = 1; i <= 5; i++) begin
            if (exp_a.size() < 4) exp_a.push_back(8'(i));
            tx_frame_a(8'(i));
        end
        check("ovr_count", ifa.rx_count, 4);
        check("ovr_flag", ifa.overrun, 1);
        for (int i = 0; i < 4; i++) rx_pop_a();
        check("ovr_drained", ifa.valid, 0);
        ifa.clr_err = 1'b1;
        @(negedge clk);
        ifa.clr_err = 1'b0;
        check("ovr_cleared", ifa.overrun, 0);

        // reset during data bit 3 of 0x00
        ifa.tx_data = 8'h00;
        ifa.wr = 1'b1;
        @(negedge clk);
        ifa.wr = 1'b0;
        repeat (287) @(negedge clk);
        check("pre_reset_tx", tx_a, 0);
        resetq_a = 1'b0;
        #1;
        check("async_rst_tx", tx_a, 1);
        check("async_rst_busy", ifa.busy, 0);
        @(negedge clk);
        resetq_a = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_valid", ifa.valid, 0);
        exp_a.push_back(8'h55);
        tx_frame_a(8'h55);
        rx_pop_a();
        check("post_rst_empty", ifa.rx_count, 0);

        // 8E1 receiver: good frame
        exp_b.push_back(8'h5A);
        drive_b(8'h5A, ^8'h5A, 1'b1);
        check("b_good_flags", {ifb.frame_err, ifb.parity_err, ifb.overrun}, 0);
        rx_pop_b();

        // 0x01 with parity bit 0 (even parity needs 1)
        drive_b(8'h01, 1'b0, 1'b1);
        check("b_par_err", ifb.parity_err, 1);
        check("b_par_valid", ifb.valid, 0);
        pulse_clr_b();
        check("b_par_clr", ifb.parity_err, 0);

        // correct parity, stop bit low
        drive_b(8'h33, ^8'h33, 1'b0);
        check("b_frame_err", ifb.frame_err, 1);
        check("b_frame_valid", ifb.valid, 0);
        pulse_clr_b();
        check("b_frame_clr", ifb.frame_err, 0);

        // 20-clock glitch on idle line
        rx_b = 1'b0;
        repeat (20) @(negedge clk);
        rx_b = 1'b1;
        repeat (100) @(negedge clk);
        check("b_glitch_flags", {ifb.frame_err, ifb.parity_err, ifb.overrun}, 0);
        check("b_glitch_valid", ifb.valid, 0);

        // receiver still works after errors and glitch
        exp_b.push_back(8'hC3);
        drive_b(8'hC3, ^8'hC3, 1'b1);
        rx_pop_b();
        check("b_final_count", ifb.rx_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
